toggle_monitor: RTL and testbench

Receive-side checker for the free-running toggle outputs the codebase generates, such as divided clocks and heartbeat square waves. It synchronises an asynchronous toggling input, detects both edges, and measures each half-period in clk cycles. It reports lock when consecutive half-periods match, a stall when no edge arrives within a timeout, and a glitch when a half-period is too short. It sits in the board-level debug and self-test path, feeding status LEDs and registers.

---
 rtl/toggle_monitor.sv | 167 ++++++++++++++++
 tb/tb_toggle_monitor.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/toggle_monitor.sv
// Receive-side checker for free-running toggle signals: synchronises tog_in,
// measures every half-period and reports lock, stall and glitch status.
module toggle_monitor #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1000,
  parameter int MIN_HALF    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tog_in,
  output logic             period_valid,
  output logic [CNT_W-1:0] half_period,
  output logic [CNT_W-1:0] edge_cnt,
  output logic             locked,
  output logic             stall,
  output logic             glitch,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2,
    STALL   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_M1 = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] MIN_HALF_V = CNT_W'(MIN_HALF);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   samp_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       prev_half_q;
  state_t                 state_q;
  state_t                 state_d;

  logic             edge_det;
  logic [CNT_W-1:0] meas;
  logic             timeout_hit;
  logic             short_val;
  logic             same_val;
  logic             measuring;

  logic             valid_d;
  logic             glitch_d;
  logic [CNT_W-1:0] half_d;
  logic [CNT_W-1:0] edge_cnt_d;
  logic [CNT_W-1:0] prev_half_d;

  assign edge_det  = sync_q[SYNC_STAGES-1] ^ samp_q;
  assign meas      = cnt_q + 1'b1;
  // Raised on the cycle whose edge would have reported exactly TIMEOUT.
  assign timeout_hit = (cnt_q == TIMEOUT_M1);
  assign short_val   = (meas < MIN_HALF_V);
  assign same_val    = (meas == prev_half_q);
  assign measuring   = (state_q == MEASURE) || (state_q == LOCKED);
  assign state_dbg   = state_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      samp_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], tog_in};
      samp_q <= sync_q[SYNC_STAGES-1];
      if (edge_det) begin
        cnt_q <= '0;
      end else if (cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // An edge always wins over a coincident timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (edge_det) begin
          state_d = MEASURE;
        end else if (timeout_hit) begin
          state_d = STALL;
        end
      end
      MEASURE: begin
        if (edge_det) begin
          if (!short_val && same_val) begin
            state_d = LOCKED;
          end
        end else if (timeout_hit) begin
          state_d = STALL;
        end
      end
      LOCKED: begin
        if (edge_det) begin
          if (short_val || !same_val) begin
            state_d = MEASURE;
          end
        end else if (timeout_hit) begin
          state_d = STALL;
        end
      end
      STALL: begin
        if (edge_det) begin
          state_d = MEASURE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    valid_d     = 1'b0;
    glitch_d    = 1'b0;
    half_d      = half_period;
    edge_cnt_d  = edge_cnt;
    prev_half_d = prev_half_q;
    if (edge_det) begin
      edge_cnt_d = edge_cnt + 1'b1;
      // The first interval after IDLE or STALL has no valid start edge.
      if (measuring) begin
        valid_d = 1'b1;
        half_d  = meas;
        if (short_val) begin
          glitch_d    = 1'b1;
          prev_half_d = '0;
        end else begin
          prev_half_d = meas;
        end
      end
    end else if (timeout_hit && (state_q != STALL)) begin
      prev_half_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      period_valid <= 1'b0;
      glitch       <= 1'b0;
      half_period  <= '0;
      edge_cnt     <= '0;
      prev_half_q  <= '0;
      locked       <= 1'b0;
      stall        <= 1'b0;
    end else begin
      period_valid <= valid_d;
      glitch       <= glitch_d;
      half_period  <= half_d;
      edge_cnt     <= edge_cnt_d;
      prev_half_q  <= prev_half_d;
      locked       <= (state_d == LOCKED);
      stall        <= (state_d == STALL);
    end
  end

endmodule

// File: tb/tb_toggle_monitor.sv
// Bench for toggle_monitor: timestamp-based reference model checked every
// cycle, plus directed toggle sequences with hand-computed expectations.
module tb_toggle_monitor;

  localparam int CNT_W       = 16;
  localparam int SYNC_STAGES = 2;
  localparam int TIMEOUT     = 1000;
  localparam int MIN_HALF    = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             tog_in = 1'b0;
  logic             period_valid;
  logic [CNT_W-1:0] half_period;
  logic [CNT_W-1:0] edge_cnt;
  logic             locked;
  logic             stall;
  logic             glitch;
  logic [1:0]       state_dbg;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit cmp_en = 1'b0;

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  toggle_monitor #(
    .CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES), .TIMEOUT(TIMEOUT), .MIN_HALF(MIN_HALF)
  ) dut (
    .clk(clk), .rst(rst), .tog_in(tog_in),
    .period_valid(period_valid), .half_period(half_period), .edge_cnt(edge_cnt),
    .locked(locked), .stall(stall), .glitch(glitch), .state_dbg(state_dbg)
  );

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reference model: edges as timestamps, intervals as differences
  logic             samp_q[$];
  int               m_cyc, m_last, m_prev;
  bit               m_has_ref, m_stalled;
  logic             exp_valid, exp_locked, exp_stall, exp_glitch;
  logic [CNT_W-1:0] exp_half, exp_cnt;

  task automatic model_reset();
    samp_q.delete();
    for (int i = 0; i < SYNC_STAGES + 1; i++) samp_q.push_back(1'b0);
    m_cyc = 0; m_last = 0; m_prev = 0;
    m_has_ref = 1'b0; m_stalled = 1'b0;
    exp_valid = 1'b0; exp_locked = 1'b0; exp_stall = 1'b0; exp_glitch = 1'b0;
    exp_half = '0; exp_cnt = '0;
  endtask

  task automatic model_step(input logic t);
    logic seen;
    int   interval;
    m_cyc++;
    samp_q.push_back(t);
    seen = (samp_q[0] != samp_q[1]);
    void'(samp_q.pop_front());
    exp_valid  = 1'b0;
    exp_glitch = 1'b0;
    if (seen) begin
      exp_cnt  = exp_cnt + 1'b1;
      interval = m_cyc - m_last;
      m_last   = m_cyc;
      if (!m_has_ref || m_stalled) begin
        m_has_ref = 1'b1;
        m_stalled = 1'b0;
        exp_stall = 1'b0;
      end else begin
        exp_valid = 1'b1;
        exp_half  = CNT_W'(interval);
        if (interval < MIN_HALF) begin
          exp_glitch = 1'b1;
          exp_locked = 1'b0;
          m_prev     = 0;
        end else begin
          exp_locked = (interval == m_prev);
          m_prev     = interval;
        end
      end
    end else if (!m_stalled && (m_cyc - m_last) == TIMEOUT) begin
      m_stalled  = 1'b1;
      exp_stall  = 1'b1;
      exp_locked = 1'b0;
      m_prev     = 0;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_reset();
      else model_step(tog_in);
    end
  end

  // scoreboard: every-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        check("period_valid", period_valid, exp_valid);
        check("half_period", half_period, exp_half);
        check("edge_cnt", edge_cnt, exp_cnt);
        check("locked", locked, exp_locked);
        check("stall", stall, exp_stall);
        check("glitch", glitch, exp_glitch);
      end
    end
  end

  // report capture for the directed expectations
  logic [CNT_W-1:0] exp_q[$];
  logic             rep_lock[$];
  logic             rep_glitch[$];
  int               last_edge_cyc = -1;
  int               stall_rise_cyc = -1;
  logic [CNT_W-1:0] cnt_seen = '0;
  logic             stall_seen = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (period_valid === 1'b1) begin
        exp_q.push_back(half_period);
        rep_lock.push_back(locked);
        rep_glitch.push_back(glitch);
      end
      if (edge_cnt !== cnt_seen) last_edge_cyc = cyc;
      if (stall === 1'b1 && stall_seen !== 1'b1) stall_rise_cyc = cyc;
      cnt_seen   = edge_cnt;
      stall_seen = stall;
    end
  end

  task automatic expect_report(input string name, input int half, input logic lk, input logic gl);
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: no period report, expected half_period %0d", name, half);
    end else begin
      check({name, "_half"}, exp_q.pop_front(), half);
      check({name, "_locked"}, rep_lock.pop_front(), lk);
      check({name, "_glitch"}, rep_glitch.pop_front(), gl);
    end
  endtask

  task automatic clear_reports();
    exp_q.delete();
    rep_lock.delete();
    rep_glitch.delete();
  endtask

  // driver tasks (called at a falling edge)
  task automatic hold(input logic v, input int n);
    tog_in = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_reset(input int n);
    #2 rst = 1'b0;
    tog_in = 1'b0;
    repeat (n) @(negedge clk);
    rst = 1'b1;
    clear_reports();
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_valid"}, period_valid, 0);
    check({name, "_half"}, half_period, 0);
    check({name, "_edge_cnt"}, edge_cnt, 0);
    check({name, "_locked"}, locked, 0);
    check({name, "_stall"}, stall, 0);
    check({name, "_glitch"}, glitch, 0);
    check({name, "_state"}, state_dbg, 0);
  endtask

  task automatic basic_lock(input string name);
    hold(0, 3);
    hold(1, 5); hold(0, 5); hold(1, 5); hold(0, 5);
    expect_report({name, "_r1"}, 5, 1'b0, 1'b0);
    expect_report({name, "_r2"}, 5, 1'b1, 1'b0);
    expect_report({name, "_r3"}, 5, 1'b1, 1'b0);
    check({name, "_edge_cnt"}, edge_cnt, 4);
  endtask

  int rel_cyc;

  initial begin
    @(negedge clk);
    cmp_en = 1'b1;

    // 1: reset held while toggling, then static input times out
    hold(1, 3); hold(0, 3); hold(1, 3);
    check_all_zero("s1_in_reset");
    tog_in  = 1'b0;
    rel_cyc = cyc;
    rst     = 1'b1;
    hold(0, TIMEOUT + 10);
    check("s1_stall_delay", stall_rise_cyc - rel_cyc, 1000);
    check("s1_stall", stall, 1);
    check("s1_edge_cnt", edge_cnt, 0);
    check("s1_no_reports", exp_q.size(), 0);

    // 2: 5-cycle toggling from IDLE
    apply_reset(2);
    basic_lock("s2");

    // 3: switch to 7-cycle toggling
    hold(1, 7);
    expect_report("s3_r1", 5, 1'b1, 1'b0);
    hold(0, 7);
    expect_report("s3_r2", 7, 1'b0, 1'b0);
    hold(1, 7);
    expect_report("s3_r3", 7, 1'b1, 1'b0);
    check("s3_edge_cnt", edge_cnt, 7);

    // 4: relock at 5, stop, then resume
    hold(0, 5); hold(1, 5); hold(0, 5);
    expect_report("s4_r1", 7, 1'b1, 1'b0);
    expect_report("s4_r2", 5, 1'b0, 1'b0);
    expect_report("s4_r3", 5, 1'b1, 1'b0);
    stall_rise_cyc = -1;
    hold(1, TIMEOUT + 10);
    expect_report("s4_r4", 5, 1'b1, 1'b0);
    check("s4_stall_delay", stall_rise_cyc - last_edge_cyc, 1000);
    check("s4_stall", stall, 1);
    check("s4_locked", locked, 0);
    hold(0, 5);
    check("s4_stall_cleared", stall, 0);
    check("s4_no_report", exp_q.size(), 0);
    hold(1, 5);
    expect_report("s4_r5", 5, 1'b0, 1'b0);
    hold(0, 5);
    expect_report("s4_r6", 5, 1'b1, 1'b0);
    check("s4_edge_cnt", edge_cnt, 14);

    // 5: one-cycle pulse injected into 5-cycle toggling
    hold(1, 2); hold(0, 1); hold(1, 2);
    hold(0, 5); hold(1, 5); hold(0, 5);
    expect_report("s5_r1", 5, 1'b1, 1'b0);
    expect_report("s5_r2", 2, 1'b0, 1'b0);
    expect_report("s5_r3", 1, 1'b0, 1'b1);
    expect_report("s5_r4", 2, 1'b0, 1'b0);
    expect_report("s5_r5", 5, 1'b0, 1'b0);
    expect_report("s5_r6", 5, 1'b1, 1'b0);
    check("s5_edge_cnt", edge_cnt, 20);
    check("s5_locked", locked, 1);

    // 6: asynchronous reset while locked, then start over
    hold(1, 3);
    expect_report("s6_pre", 5, 1'b1, 1'b0);
    #2 rst = 1'b0;
    #1 check_all_zero("s6_async");
    @(negedge clk);
    @(negedge clk);
    tog_in = 1'b0;
    rst = 1'b1;
    clear_reports();
    basic_lock("s6");
    hold(1, 5);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
